// File: rtl/prog_loader.sv
// prog_loader: receives a program image as a byte stream, packs each group of
// three bytes into one instruction word and writes it into program RAM at
// ascending addresses from 0. The CPU is held stalled while a load is running.
// Stream: LEN_HI, LEN_LO (word count N, big-endian), then N x {B0, B1, B2}.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  CPU_HOLD,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_HI = 4'd1;
  localparam logic [3:0] S_LEN_LO = 4'd2;
  localparam logic [3:0] S_B0     = 4'd3;
  localparam logic [3:0] S_B1     = 4'd4;
  localparam logic [3:0] S_B2     = 4'd5;
  localparam logic [3:0] S_WRITE  = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK    = 4'd9;
`endif

  logic [3:0]            state;
  logic [7:0]            len_hi;
  logic [ADDR_WIDTH:0]   len_words;
  logic [ADDR_WIDTH:0]   wcnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            b0;
  logic [7:0]            b1;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            chk;
`endif

  logic                  accept;
  logic [15:0]           len_full;
  logic                  len_bad;
  logic [ADDR_WIDTH:0]   wcnt_next;

  // Handshake, length validation and word-count lookahead
  always_comb begin
    accept    = RX_VALID & RX_READY;
    len_full  = {len_hi, RX_DATA};
    len_bad   = (len_full == 16'h0) || ({16'h0, len_full} > (32'd1 << ADDR_WIDTH));
    wcnt_next = wcnt + (ADDR_WIDTH+1)'(1);
  end

  // Status outputs decoded from the current state
  always_comb begin
    RX_READY  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_B0) ||
                (state == S_B1) || (state == S_B2)
`ifdef PROG_LOADER_CHECKSUM_EN
                || (state == S_CHK)
`endif
                ;
    CPU_HOLD  = (state != S_IDLE) && (state != S_DONE);
    LOAD_DONE = (state == S_DONE);
    LOAD_ERR  = (state == S_ERR);
  end

  // Load sequencer: byte capture, word packing, RAM write strobe, address counting
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      len_words <= '0;
      wcnt      <= '0;
      addr      <= '0;
      b0        <= '0;
      b1        <= '0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            state <= S_LEN_HI;
            addr  <= '0;
            wcnt  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk   <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= RX_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk    <= chk ^ RX_DATA;
`endif
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            chk <= chk ^ RX_DATA;
`endif
            if (len_bad) begin
              state <= S_ERR;
            end else begin
              len_words <= len_full[ADDR_WIDTH:0];
              state     <= S_B0;
            end
          end
        end
        S_B0: begin
          if (accept) begin
            b0    <= RX_DATA[1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            chk   <= chk ^ RX_DATA;
`endif
            state <= S_B1;
          end
        end
        S_B1: begin
          if (accept) begin
            b1    <= RX_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk   <= chk ^ RX_DATA;
`endif
            state <= S_B2;
          end
        end
        S_B2: begin
          if (accept) begin
            WR_EN   <= 1'b1;
            WR_ADDR <= addr;
            WR_DATA <= DATA_WIDTH'({b0, b1, RX_DATA});
`ifdef PROG_LOADER_CHECKSUM_EN
            chk     <= chk ^ RX_DATA;
`endif
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Completion is judged by the written-word count, not the address,
          // so a full-depth image ends cleanly even though addr wraps to 0.
          WR_EN <= 1'b0;
          addr  <= addr + 1'b1;
          wcnt  <= wcnt_next;
          if (wcnt_next == len_words) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state <= S_CHK;
`else
            state <= S_DONE;
`endif
          end else begin
            state <= S_B0;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            state <= (RX_DATA == chk) ? S_DONE : S_ERR;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
